// File: rtl/adc_cond_pkg.sv
// Shared constants and types for the ADC conditioning stage.
package adc_cond_pkg;

    localparam int ADC_W          = 8;
    localparam int WCNT_W         = 16;
    localparam int DIV_DEFAULT    = 1;
    localparam int LOG2_N_DEFAULT = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } samp_state_e;

    // Accumulator width that holds 2^log2_n full-scale samples without overflow.
    function automatic int acc_width(input int log2_n);
        return ADC_W + log2_n;
    endfunction

endpackage

// File: rtl/adc_sample_prescaler.sv
// Sample-rate prescaler: one tick every DIV enabled cycles, restarts when enable drops.
module adc_sample_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;

    assign tick = enable && (div_cnt_q == DIV_LAST);

    always_comb begin
        // NOTE: default assigned first so no path leaves div_cnt_d unassigned (no latch).
        div_cnt_d = div_cnt_q;
        if (!enable || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/adc_window_averager.sv
// Decimates the ADC stream, averages 2^LOG2_N-sample windows and publishes
// mean/min/max over valid/ready, flagging windows dropped under backpressure.
module adc_window_averager
    import adc_cond_pkg::*;
#(
    parameter int DIV    = DIV_DEFAULT,
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADC_W-1:0]  adc_in,
    input  logic              enable,
    input  logic              clr_overrun,
    input  logic              avg_ready,
    output logic              avg_valid,
    output logic [ADC_W-1:0]  avg_data,
    output logic [ADC_W-1:0]  win_max,
    output logic [ADC_W-1:0]  win_min,
    output logic              overrun,
    output logic [WCNT_W-1:0] win_count
);

    localparam int ACC_W = acc_width(LOG2_N);
    localparam int IDX_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((2 ** LOG2_N) - 1);

    samp_state_e       state_q, state_d;
    logic [ADC_W-1:0]  adc_q, adc_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADC_W-1:0]  run_max_q, run_max_d;
    logic [ADC_W-1:0]  run_min_q, run_min_d;
    logic              avg_valid_q, avg_valid_d;
    logic [ADC_W-1:0]  avg_data_q, avg_data_d;
    logic [ADC_W-1:0]  win_max_q, win_max_d;
    logic [ADC_W-1:0]  win_min_q, win_min_d;
    logic              overrun_q, overrun_d;
    logic [WCNT_W-1:0] win_count_q, win_count_d;

    logic              tick;
    logic [ACC_W-1:0]  acc_sum;
    logic [ADC_W-1:0]  sample_max, sample_min;
    logic              win_end, publish, transfer;

    adc_sample_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Sampling-side FSM: leaving ACCUM flushes the partial window (see datapath below).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable)  state_d = S_ACCUM;
            S_ACCUM: if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adc_d     = adc_in;
        acc_d     = acc_q;
        idx_d     = idx_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        win_end   = 1'b0;

        acc_sum    = acc_q + ACC_W'(adc_q);
        sample_max = (idx_q == '0 || adc_q > run_max_q) ? adc_q : run_max_q;
        sample_min = (idx_q == '0 || adc_q < run_min_q) ? adc_q : run_min_q;

        if (!enable) begin
            acc_d     = '0;
            idx_d     = '0;
            run_max_d = '0;
            run_min_d = '0;
        end else if (tick) begin
            run_max_d = sample_max;
            run_min_d = sample_min;
            if (idx_q == IDX_LAST) begin
                win_end = 1'b1;
                acc_d   = '0;
                idx_d   = '0;
            end else begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output side: a one-deep result buffer; a full, unread buffer drops new windows.
    always_comb begin
        avg_valid_d = avg_valid_q;
        avg_data_d  = avg_data_q;
        win_max_d   = win_max_q;
        win_min_d   = win_min_q;
        overrun_d   = overrun_q;

        transfer    = avg_valid_q && avg_ready;
        publish     = win_end && (!avg_valid_q || avg_ready);
        win_count_d = win_count_q + WCNT_W'(win_end);

        if (clr_overrun) overrun_d = 1'b0;

        if (publish) begin
            avg_valid_d = 1'b1;
            avg_data_d  = acc_sum[ACC_W-1:LOG2_N];
            win_max_d   = sample_max;
            win_min_d   = sample_min;
        end else if (win_end) begin
            overrun_d = 1'b1;
        end else if (transfer) begin
            avg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            adc_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            run_max_q   <= '0;
            run_min_q   <= '0;
            avg_valid_q <= 1'b0;
            avg_data_q  <= '0;
            win_max_q   <= '0;
            win_min_q   <= '0;
            overrun_q   <= 1'b0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            adc_q       <= adc_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            run_max_q   <= run_max_d;
            run_min_q   <= run_min_d;
            avg_valid_q <= avg_valid_d;
            avg_data_q  <= avg_data_d;
            win_max_q   <= win_max_d;
            win_min_q   <= win_min_d;
            overrun_q   <= overrun_d;
            win_count_q <= win_count_d;
        end
    end

    assign avg_valid = avg_valid_q;
    assign avg_data  = avg_data_q;
    assign win_max   = win_max_q;
    assign win_min   = win_min_q;
    assign overrun   = overrun_q;
    assign win_count = win_count_q;

endmodule

// File: tb/tb_adc_window_averager.sv
// Bench for adc_window_averager: two configurations (DIV=1/LOG2_N=2 and DIV=3/LOG2_N=1)
// share stimulus; a sample-list model is compared every cycle, plus literal spot checks.
module tb_adc_window_averager;
    import adc_cond_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adc_in;
    logic       enable;
    logic       clr_overrun;
    logic       avg_ready;

    logic        a_valid, b_valid, a_ovr, b_ovr;
    logic [7:0]  a_avg, a_max, a_min, b_avg, b_max, b_min;
    logic [15:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adc_window_averager #(.DIV(1), .LOG2_N(2)) dut_a (
        .clk(clk), .reset(reset), .adc_in(adc_in), .enable(enable),
        .clr_overrun(clr_overrun), .avg_ready(avg_ready),
        .avg_valid(a_valid), .avg_data(a_avg), .win_max(a_max), .win_min(a_min),
        .overrun(a_ovr), .win_count(a_cnt)
    );

    adc_window_averager #(.DIV(3), .LOG2_N(1)) dut_b (
        .clk(clk), .reset(reset), .adc_in(adc_in), .enable(enable),
        .clr_overrun(clr_overrun), .avg_ready(avg_ready),
        .avg_valid(b_valid), .avg_data(b_avg), .win_max(b_max), .win_min(b_min),
        .overrun(b_ovr), .win_count(b_cnt)
    );

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int l2_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [41:0] dut_out(input int i);
        if (i == 0) return {a_valid, a_avg, a_max, a_min, a_ovr, a_cnt};
        return {b_valid, b_avg, b_max, b_min, b_ovr, b_cnt};
    endfunction

    // Model: list of samples taken in the current window, result buffer, counters.
    int          m_div [2];
    int          m_n   [2];
    logic [7:0]  m_s   [2][64];
    logic        m_valid [2];
    logic [7:0]  m_avg [2];
    logic [7:0]  m_max [2];
    logic [7:0]  m_min [2];
    logic        m_ovr [2];
    logic [15:0] m_cnt [2];
    logic [7:0]  m_prev;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_div[i] = 0; m_n[i] = 0; m_valid[i] = 1'b0;
                m_avg[i] = 8'h00; m_max[i] = 8'h00; m_min[i] = 8'h00;
                m_ovr[i] = 1'b0; m_cnt[i] = 16'h0000;
            end
            m_prev = 8'h00;
            m_live = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit         done;
                bit         xfer;
                int         sum;
                logic [7:0] mx;
                logic [7:0] mn;
                done = 1'b0;
                sum  = 0;
                mx   = 8'h00;
                mn   = 8'h00;
                xfer = m_valid[i] && avg_ready;
                if (!enable) begin
                    m_div[i] = 0;
                    m_n[i]   = 0;
                end else if (m_div[i] == div_of(i) - 1) begin
                    m_div[i] = 0;
                    m_s[i][m_n[i]] = m_prev;
                    m_n[i]++;
                    if (m_n[i] == (1 << l2_of(i))) begin
                        mx = m_s[i][0];
                        mn = m_s[i][0];
                        for (int j = 0; j < m_n[i]; j++) begin
                            sum += int'(m_s[i][j]);
                            if (m_s[i][j] > mx) mx = m_s[i][j];
                            if (m_s[i][j] < mn) mn = m_s[i][j];
                        end
                        m_n[i] = 0;
                        m_cnt[i]++;
                        done = 1'b1;
                    end
                end else begin
                    m_div[i]++;
                end
                if (clr_overrun) m_ovr[i] = 1'b0;
                if (done && (!m_valid[i] || avg_ready)) begin
                    m_valid[i] = 1'b1;
                    m_avg[i]   = 8'((sum >> l2_of(i)) & 255);
                    m_max[i]   = mx;
                    m_min[i]   = mn;
                end else if (done) begin
                    m_ovr[i] = 1'b1;
                end else if (xfer) begin
                    m_valid[i] = 1'b0;
                end
            end
            m_prev = adc_in;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                check((i == 0) ? "model_a" : "model_b", dut_out(i),
                      {m_valid[i], m_avg[i], m_max[i], m_min[i], m_ovr[i], m_cnt[i]});
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic e, input logic r, input logic c);
        adc_in      = a;
        enable      = e;
        avg_ready   = r;
        clr_overrun = c;
        @(posedge clk);
        #1;
    endtask

    // Flush cycle carries v0 into adc_q, so instance A samples v0..v3 as one window.
    task automatic feed4(input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3, input logic r);
        drive(v0, 1'b0, r, 1'b0);
        drive(v1, 1'b1, r, 1'b0);
        drive(v2, 1'b1, r, 1'b0);
        drive(v3, 1'b1, r, 1'b0);
        drive(v3, 1'b1, r, 1'b0);
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        check("reset_a", dut_out(0), 42'h0);
        check("reset_b", dut_out(1), 42'h0);

        // Ramp windows: sums 6 and 22.
        feed4(8'h00, 8'h01, 8'h02, 8'h03, 1'b1);
        check("ramp1", {a_valid, a_avg, a_min, a_max, a_cnt},
              {1'b1, 8'h01, 8'h00, 8'h03, 16'd1});
        feed4(8'h04, 8'h05, 8'h06, 8'h07, 1'b1);
        check("ramp2", {a_valid, a_avg, a_min, a_max, a_cnt},
              {1'b1, 8'h05, 8'h04, 8'h07, 16'd2});
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("valid_pulse_end", 42'(a_valid), 42'h0);

        // Full-scale and wrapping windows.
        feed4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        check("full_scale", {a_avg, a_min, a_max}, {8'hFF, 8'hFF, 8'hFF});
        feed4(8'hFE, 8'hFF, 8'h00, 8'h01, 1'b1);
        check("wrap_ramp", {a_avg, a_min, a_max, a_cnt}, {8'h7F, 8'h00, 8'hFF, 16'd4});

        // Constant 0x40 with ready held high: one-cycle valid pulse per window.
        pulses = 0;
        drive(8'h40, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            drive(8'h40, 1'b1, 1'b1, 1'b0);
            if (a_valid) pulses++;
        end
        check("const_pulses", 42'(pulses), 42'd3);
        check("const_result", {a_avg, a_min, a_max, a_cnt}, {8'h40, 8'h40, 8'h40, 16'd7});

        // Backpressure: three windows, first held, the other two dropped.
        drive(8'h10, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) drive((k <= 3) ? 8'h10 : 8'h20, 1'b1, 1'b0, 1'b0);
        check("bp_hold", {a_valid, a_avg, a_min, a_max, a_ovr, a_cnt},
              {1'b1, 8'h10, 8'h10, 8'h10, 1'b1, 16'd10});
        drive(8'h20, 1'b0, 1'b1, 1'b0);
        check("bp_transfer", {a_valid, a_avg, a_ovr}, {1'b0, 8'h10, 1'b1});
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_overrun", 42'(a_ovr), 42'h0);

        // DIV=3, LOG2_N=1: partial window of one sample discarded by enable low.
        drive(8'h80, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(8'h80, 1'b1, 1'b1, 1'b0);
        drive(8'h20, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(8'h20, 1'b1, 1'b1, 1'b0);
            if (k == 3)  check("b_no_early_end", 42'(b_valid), 42'h0);
            if (k == 5)  check("b_not_yet", 42'(b_valid), 42'h0);
            if (k == 6)  check("b_window1", {b_valid, b_avg, b_min, b_max},
                               {1'b1, 8'h20, 8'h20, 8'h20});
            if (k == 11) check("b_gap", 42'(b_valid), 42'h0);
            if (k == 12) check("b_window2", 42'(b_valid), 42'h1);
        end

        // Reset mid-window while a result is pending.
        drive(8'h30, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(8'h30, 1'b1, 1'b0, 1'b0);
        check("pre_reset_valid", 42'(a_valid), 42'h1);
        reset = 1'b1;
        drive(8'h08, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        check("mid_reset_a", dut_out(0), 42'h0);
        check("mid_reset_b", dut_out(1), 42'h0);
        for (int k = 0; k < 4; k++) drive(8'h08, 1'b1, 1'b1, 1'b0);
        check("post_reset", {a_valid, a_avg, a_min, a_max, a_cnt},
              {1'b1, 8'h06, 8'h00, 8'h08, 16'd1});

        drive(8'h00, 1'b0, 1'b1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_window_averager.md
Name: adc_window_averager

Overview:
Conditioning stage directly upstream of test_top's 8-bit ADC input.
- Decimates the raw 8-bit ADC stream with a prescaler.
- Averages windows of 2^LOG2_N samples.
- Publishes each window's mean, min and max through a valid/ready handshake.
- Flags results dropped under backpressure, so the downstream counter/LED logic sees a slower, de-noised sample stream.

Parameters:
- DIV, 1, prescaler ratio: one sample taken every DIV clk cycles while enabled (legal 1..255).
- LOG2_N, 2, window length exponent: window = 2^LOG2_N samples (legal 0..6).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset (see Behaviour).
- adc_in  input  8  raw unsigned ADC code.
- enable  input  1  run sampling; low halts and discards the partial window.
- clr_overrun  input  1  one-cycle pulse, clears the overrun flag.
- avg_ready  input  1  consumer accepts result this cycle.
- avg_valid  output  1  result registers hold an unconsumed window result.
- avg_data  output  8  window mean, truncated: sum >> LOG2_N.
- win_max  output  8  largest sample of the published window.
- win_min  output  8  smallest sample of the published window.
- overrun  output  1  sticky: a completed window was dropped.
- win_count  output  16  number of windows completed since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All registers clear to 0 on reset: avg_valid, avg_data, win_max, win_min, overrun, win_count, accumulator, sample index, prescaler, adc_q. Reset overrides every other input. Reset mid-window discards the partial window.
- Input stage: adc_q <= adc_in every cycle, unconditionally.
- Prescaler:
  - div_cnt counts 0..DIV-1 while enable=1; tick = enable && div_cnt==DIV-1.
  - DIV=1 gives a tick every enabled cycle.
  - enable=0: div_cnt <= 0, sample index <= 0, accumulator <= 0, running min/max reinitialised. The output registers are untouched.
- Accumulate, on each tick:
  - acc (width 8+LOG2_N, cannot overflow) += adc_q; run_max/run_min updated with adc_q.
  - The first sample of a window loads run_max = run_min = adc_q.
  - idx increments.
- Window end: a tick with idx == 2^LOG2_N-1 finishes the window.
  - result = (acc+adc_q) >> LOG2_N; max/min include adc_q.
  - acc and idx are cleared in the same cycle.
  - win_count increments.
- Publish: at window end, if avg_valid==0 or avg_ready==1, avg_data/win_max/win_min <= result and avg_valid <= 1.
- Drop: otherwise (valid && !ready) the old result is held and the new result is discarded. overrun <= 1 and win_count still increments.
- Handshake:
  - Transfer occurs on a cycle with avg_valid && avg_ready.
  - After a transfer with no simultaneous window end, avg_valid <= 0; data outputs keep their last value.
  - Outputs must not change while avg_valid && !avg_ready.
- Latency: the last sample of a window is present on adc_in in cycle t (the cycle before its tick edge's adc_q capture). avg_valid is high in cycle t+2 (LOG2_N=0, DIV=1: every adc_in value appears on avg_data 2 cycles later).
- overrun: set as above; cleared by clr_overrun. If set and clear fall in the same cycle, set wins.
- FSM (sampling side): IDLE (enable=0), ACCUM (enable=1). ACCUM -> IDLE on enable=0 with state flush as above. The output side is an independent FULL/EMPTY flag (avg_valid).

Decomposition:
- Package adc_cond_pkg:
  - ADC_W=8, WCNT_W=16.
  - Default DIV/LOG2_N constants.
  - Function acc_width(LOG2_N) = ADC_W+LOG2_N.
- One sub-module: adc_sample_prescaler (div_cnt, tick, flush on enable low). The accumulator, min/max and handshake stay in the top.

Test Plan:
- DIV=1, LOG2_N=2, adc_in held 0x40, ready=1 -> avg_data 0x40, min=max=0x40, avg_valid pulses one cycle every 4 cycles, win_count 1,2,3...
- DIV=1, LOG2_N=2, incrementing ramp 0,1,2,3,4... from reset release, ready=1 -> first result avg 0x01 (sum 6), min 0x00, max 0x03. Second result avg 0x05 (sum 22), min 0x04, max 0x07.
- Four samples of 0xFF -> acc 0x3FC, avg 0xFF, no overflow. Ramp wrapping 0xFE,0xFF,0x00,0x01 -> avg 0x7F, min 0x00, max 0xFF.
- ready=0 for 3 windows of constant 0x10 then 0x20 -> first result (0x10) held stable, overrun=1, win_count=3. Raise ready -> one transfer of 0x10. Pulse clr_overrun -> overrun=0.
- DIV=3, LOG2_N=1 -> tick every 3rd cycle, avg_valid every 6 cycles. Drop enable mid-window after 1 sample, re-enable -> partial window discarded, next result uses only new samples.
- Assert reset for 1 cycle mid-window with avg_valid=1 -> next cycle all outputs 0, the following window result uses only post-reset samples.
